// File: rtl/pipe_flush_ctrl.sv
// pipe_flush_ctrl
//   Pipeline reset/flush sequencer for the 5-stage CPU. Stretches the global
//   reset into a multi-cycle pipeline reset and turns single-cycle flush
//   requests into per-stage clear pulses held for a fixed number of cycles.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   flush        in   flush request, sampled on every clock edge
//   flush_stage  in   oldest stage to clear (stages 0..flush_stage cleared)
//   reset_out    out  stretched pipeline reset
//   stage_clr    out  per-stage synchronous clear to the pipeline registers
//   stall_fetch  out  holds the PC while any clear is active
//   busy         out  sequencer is not idle
//   flush_count  out  saturating count of accepted flushes
//
// Configuration
//   FLUSH_STATS_EN  when defined, builds the flush_count statistics counter;
//                   otherwise flush_count is tied to zero.

module pipe_flush_ctrl #(
  parameter int unsigned NUM_STAGES   = 5,
  parameter int unsigned FLUSH_CYCLES = 3,
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned SIDX_W       = 3,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [SIDX_W-1:0]     flush_stage,
  output logic                  reset_out,
  output logic [NUM_STAGES-1:0] stage_clr,
  output logic                  stall_fetch,
  output logic                  busy,
  output logic [CNT_W-1:0]      flush_count
);

  // Down-counter must hold both the reset stretch and the flush reload.
  localparam int unsigned CNT_MAX  = (RESET_CYCLES > FLUSH_CYCLES) ? RESET_CYCLES : FLUSH_CYCLES;
  localparam int unsigned CW       = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam int unsigned LAST_STG = NUM_STAGES - 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RST_HOLD   = 2'd1,
    FLUSH_HOLD = 2'd2
  } state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [NUM_STAGES-1:0]   req_mask;
  int unsigned             sel_stage;

  // Thermometer mask of stages 0..flush_stage, clamped to the oldest stage.
  always_comb begin
    sel_stage = 32'(flush_stage);
    if (sel_stage > LAST_STG) begin
      sel_stage = LAST_STG;
    end
    req_mask = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (i <= sel_stage) begin
        req_mask[i] = 1'b1;
      end
    end
  end

  // Sequencer: state, counter and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RST_HOLD;
      cnt         <= CW'(RESET_CYCLES);
      reset_out   <= 1'b1;
      stage_clr   <= '1;
      stall_fetch <= 1'b1;
      busy        <= 1'b1;
    end else begin
      case (state)
        RST_HOLD: begin
          // Flush requests are ignored until the reset stretch completes.
          if (cnt == '0) begin
            state       <= IDLE;
            reset_out   <= 1'b0;
            stage_clr   <= '0;
            stall_fetch <= 1'b0;
            busy        <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        IDLE: begin
          if (flush) begin
            state       <= FLUSH_HOLD;
            cnt         <= CW'(FLUSH_CYCLES - 1);
            stage_clr   <= req_mask;
            stall_fetch <= 1'b1;
            busy        <= 1'b1;
          end
        end
        FLUSH_HOLD: begin
          // A new request merges masks and restarts the hold, even on the
          // last hold cycle, so there is never a gap between clears.
          if (flush) begin
            cnt       <= CW'(FLUSH_CYCLES - 1);
            stage_clr <= stage_clr | req_mask;
          end else if (cnt == '0) begin
            state       <= IDLE;
            stage_clr   <= '0;
            stall_fetch <= 1'b0;
            busy        <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state       <= IDLE;
          cnt         <= '0;
          reset_out   <= 1'b0;
          stage_clr   <= '0;
          stall_fetch <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

`ifdef FLUSH_STATS_EN
  // Saturating count of flushes accepted outside the reset stretch.
  always_ff @(posedge clock) begin
    if (reset) begin
      flush_count <= '0;
    end else if (flush && (state != RST_HOLD) && (flush_count != '1)) begin
      flush_count <= flush_count + CNT_W'(1);
    end
  end
`else
  assign flush_count = '0;
`endif

endmodule
